pkt_arbiter: RTL and testbench
==============================

PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, packet beat data width.
REQ-003 SHALL have parameter WDOG_CYCLES, default 64, stall limit in cycles (used only with PKT_ARB_WDOG_EN).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_sop  in  NUM_REQ  per-requester start-of-packet.
REQ-008 SHALL have port req_eop  in  NUM_REQ  per-requester end-of-packet.
REQ-009 SHALL have port req_data  in  NUM_REQ*DATA_W  packed beats; requester i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port req_ready  out  NUM_REQ  per-requester beat accept.
REQ-011 SHALL have ports out_valid, out_sop, out_eop  out  1 each, plus out_data  out  DATA_W  shared pkt output.
REQ-012 SHALL have port out_ready  in  1  downstream accept.
REQ-013 SHALL have port grant_id  out  $clog2(NUM_REQ)  locked requester index.
REQ-014 SHALL have port busy  out  1  high while a packet is locked.
REQ-015 SHALL have port wdog_err  out  1  one-cycle stall-abort pulse (present only with PKT_ARB_WDOG_EN).

Function
REQ-016 SHALL implement states IDLE and LOCKED.
REQ-017 In IDLE, if any req_valid is high, SHALL select the first valid requester after last_grant (round-robin, wrapping NUM_REQ-1 -> 0), register it in grant_id, and enter LOCKED next cycle.
REQ-018 In IDLE, SHALL drive out_valid=0 and req_ready=0 (one-cycle arbitration bubble per packet).
REQ-019 In LOCKED, SHALL forward requester grant_id combinationally: out_valid/sop/eop/data = req_*[grant_id]; req_ready[grant_id]=out_ready; all other req_ready=0.
REQ-020 A beat transfers when out_valid & out_ready; zero added latency in LOCKED.
REQ-021 On a transferred beat with out_eop=1, SHALL update last_grant=grant_id and return to IDLE next cycle.
REQ-022 Grant SHALL NOT change mid-packet regardless of other requesters' valid activity.
REQ-023 A single-beat packet (sop=eop=1) SHALL complete in one LOCKED cycle when out_ready=1.
REQ-024 With only one requester active, SHALL re-grant that same requester after each bubble.
REQ-025 busy SHALL equal (state==LOCKED).
REQ-026 Requester sop correctness is not checked; arbitration is purely per eop.

Reset
REQ-027 On rst=1 at a clock edge, SHALL enter IDLE, set grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), busy=0, wdog counter=0, wdog_err=0.
REQ-028 Reset mid-packet SHALL abandon the packet; out_valid and all req_ready SHALL be 0 from the cycle after reset is sampled.

Configuration
REQ-029 Macro PKT_ARB_WDOG_EN SHALL compile in a watchdog: in LOCKED, a counter increments each cycle without a transferred beat, clears on any transferred beat; on reaching WDOG_CYCLES, SHALL pulse wdog_err for one cycle, set last_grant=grant_id, return to IDLE.
REQ-030 Without PKT_ARB_WDOG_EN, the wdog_err port and counter SHALL be absent and LOCKED persists indefinitely until eop.

Verification
REQ-031 Reset then req_valid=4'b0001, 3-beat packet, out_ready=1 -> grant_id=0, busy rises 1 cycle after valid, 3 beats output on consecutive cycles, IDLE after eop.
REQ-032 All 4 requesters continuously send 2-beat packets -> grant order 0,1,2,3,0; each packet followed by exactly one bubble cycle.
REQ-033 Requester 1 locked on 4-beat packet, requester 0 asserts valid at beat 2 -> no grant change until requester 1 eop; then grant_id=2 skipped if idle, requester 0 granted next.
REQ-034 out_ready toggling 1,0,1,0 during a 3-beat packet -> beats held stable while out_ready=0, req_ready[g] mirrors out_ready, 3 beats delivered in 5 cycles.
REQ-035 rst asserted on beat 2 of a 4-beat packet -> next cycle busy=0, out_valid=0, req_ready=0; next grant goes to requester 0.
REQ-036 With PKT_ARB_WDOG_EN, WDOG_CYCLES=8, granted requester drops valid after sop -> wdog_err pulses exactly 8 cycles later, busy falls, next requester is arbitrated.

Source files
------------

// File: rtl/pkt_arbiter.sv
// Round-robin packet arbiter: locks one requester per packet, releases on eop.
// Define PKT_ARB_WDOG_EN to add the stall watchdog and its wdog_err pulse.
module pkt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_sop,
    input  logic [NUM_REQ-1:0]        req_eop,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy
`ifdef PKT_ARB_WDOG_EN
   ,output logic                      wdog_err
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] next_grant;
    logic [GW-1:0] cand;
    logic          found;
    logic          xfer;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
        $error("pkt_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    assign busy = (state == LOCKED);
    assign xfer = out_valid & out_ready;

    // Scan starts one past last_grant so the previous winner goes last.
    always_comb begin
        next_grant = last_grant;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        req_ready = '0;
        if (state == LOCKED) begin
            out_valid           = req_valid[grant_id];
            out_sop             = req_sop[grant_id];
            out_eop             = req_eop[grant_id];
            out_data            = req_data[int'(grant_id)*DATA_W +: DATA_W];
            req_ready[grant_id] = out_ready;
        end
    end

`ifdef PKT_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    logic [CW-1:0] wdog_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
`ifdef PKT_ARB_WDOG_EN
            wdog_cnt   <= '0;
            wdog_err   <= 1'b0;
`endif
        end else begin
`ifdef PKT_ARB_WDOG_EN
            wdog_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= next_grant;
                        state    <= LOCKED;
                    end
`ifdef PKT_ARB_WDOG_EN
                    wdog_cnt <= '0;
`endif
                end
                LOCKED: begin
                    if (xfer && out_eop) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
`ifdef PKT_ARB_WDOG_EN
                    // Abort a stalled packet so other requesters are not starved.
                    if (xfer) begin
                        wdog_cnt <= '0;
                    end else if (wdog_cnt == CW'(WDOG_CYCLES - 1)) begin
                        wdog_cnt   <= '0;
                        wdog_err   <= 1'b1;
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed bench for pkt_arbiter: arbitration order, locking, backpressure, reset.
// Watchdog scenario is built only when PKT_ARB_WDOG_EN is defined.
module tb_pkt_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_sop;
    logic [N-1:0]   req_eop;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_sop;
    logic           out_eop;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef PKT_ARB_WDOG_EN
    logic           wdog_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pkt_arbiter #(
        .NUM_REQ(N),
        .DATA_W(W),
        .WDOG_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_sop(req_sop),
        .req_eop(req_eop),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .out_data(out_data),
        .out_ready(out_ready),
        .grant_id(grant_id),
        .busy(busy)
`ifdef PKT_ARB_WDOG_EN
       ,.wdog_err(wdog_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_sop   = '0;
        req_eop   = '0;
        req_data  = '0;
    endtask

    task automatic set_beat(input int i, input logic v, input logic s,
                            input logic e, input logic [W-1:0] d);
        req_valid[i]       = v;
        req_sop[i]         = s;
        req_eop[i]         = e;
        req_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_all();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        clr_all();
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_single_packet();
        do_reset();
        out_ready = 1'b1;
        set_beat(0, 1'b1, 1'b1, 1'b0, 32'hA0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_bubble_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_bubble_valid: got %b want 0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_bubble_ready: got %b want 0000", req_ready); end
        step();
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", grant_id); end
        checks++; if (out_valid !== 1'b1 || out_sop !== 1'b1) begin errors++; $display("FAIL single_b0_flags: got v=%b s=%b want 1 1", out_valid, out_sop); end
        checks++; if (out_data !== 32'hA0) begin errors++; $display("FAIL single_b0_data: got %h want a0", out_data); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        step();
        set_beat(0, 1'b1, 1'b0, 1'b0, 32'hA1);
        #1;
        checks++; if (out_data !== 32'hA1 || out_sop !== 1'b0) begin errors++; $display("FAIL single_b1: got %h sop=%b want a1 0", out_data, out_sop); end
        step();
        set_beat(0, 1'b1, 1'b0, 1'b1, 32'hA2);
        #1;
        checks++; if (out_data !== 32'hA2 || out_eop !== 1'b1) begin errors++; $display("FAIL single_b2: got %h eop=%b want a2 1", out_data, out_eop); end
        step();
        set_beat(0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after_eop: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int beat [N];
        logic [N-1:0] rdy;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) beat[i] = 0;
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < N; i++)
                set_beat(i, 1'b1, beat[i] == 0, beat[i] == 1, i*16 + beat[i]);
            #1;
            checks++; if (busy !== ((c % 3) != 0)) begin errors++; $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, (c % 3) != 0); end
            if ((c % 3) != 0) begin
                checks++; if (grant_id !== 2'((c / 3) % 4)) begin errors++; $display("FAIL rr_grant c=%0d: got %0d want %0d", c, grant_id, (c / 3) % 4); end
                checks++; if (out_data !== ((c / 3) % 4) * 16 + (c % 3) - 1) begin errors++; $display("FAIL rr_data c=%0d: got %0d want %0d", c, out_data, ((c / 3) % 4) * 16 + (c % 3) - 1); end
                checks++; if (out_eop !== ((c % 3) == 2)) begin errors++; $display("FAIL rr_eop c=%0d: got %b want %b", c, out_eop, (c % 3) == 2); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_bubble c=%0d: got %b want 0", c, out_valid); end
            end
            rdy = req_ready;
            step();
            for (int i = 0; i < N; i++)
                if (rdy[i]) beat[i] = (beat[i] + 1) % 2;
        end
        clr_all();
    endtask

    task automatic test_no_preempt();
        do_reset();
        out_ready = 1'b1;
        set_beat(1, 1'b1, 1'b1, 1'b0, 100);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL np_bubble: got %b want 0", busy); end
        step();
        for (int b = 0; b < 4; b++) begin
            set_beat(1, 1'b1, b == 0, b == 3, 100 + b);
            if (b >= 2) set_beat(0, 1'b1, 1'b1, 1'b1, 32'h55);
            #1;
            checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL np_grant b=%0d: got %0d want 1", b, grant_id); end
            checks++; if (out_data !== 100 + b) begin errors++; $display("FAIL np_data b=%0d: got %0d want %0d", b, out_data, 100 + b); end
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL np_ready b=%0d: got %b want 0010", b, req_ready); end
            step();
        end
        set_beat(1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL np_release: got %b want 0", busy); end
        step();
        checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL np_next_grant: got %0d busy=%b want 0 1", grant_id, busy); end
        checks++; if (out_data !== 32'h55) begin errors++; $display("FAIL np_next_data: got %h want 55", out_data); end
        step();
        clr_all();
    endtask

    task automatic test_backpressure();
        int pat [5] = '{1, 0, 1, 0, 1};
        int expb [5] = '{0, 1, 1, 2, 2};
        int beat = 0;
        logic r;
        out_ready = 1'b1;
        set_beat(0, 1'b1, 1'b1, 1'b0, 200);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_bubble: got %b want 0", busy); end
        step();
        for (int c = 0; c < 5; c++) begin
            out_ready = pat[c] != 0;
            set_beat(0, 1'b1, beat == 0, beat == 2, 200 + beat);
            #1;
            checks++; if (out_data !== 200 + expb[c]) begin errors++; $display("FAIL bp_data c=%0d: got %0d want %0d", c, out_data, 200 + expb[c]); end
            checks++; if (req_ready !== {3'b000, pat[c] != 0}) begin errors++; $display("FAIL bp_ready c=%0d: got %b want %0d", c, req_ready, pat[c]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy c=%0d: got %b want 1", c, busy); end
            r = req_ready[0];
            step();
            if (r) beat++;
        end
        set_beat(0, 1'b0, 1'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_done: got %b want 0", busy); end
        checks++; if (beat !== 3) begin errors++; $display("FAIL bp_beats: got %0d want 3", beat); end
    endtask

    task automatic test_reset_mid_packet();
        out_ready = 1'b1;
        set_beat(2, 1'b1, 1'b1, 1'b0, 300);
        step();
        #1;
        checks++; if (grant_id !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_lock: got %0d v=%b want 2 1", grant_id, out_valid); end
        step();
        set_beat(2, 1'b1, 1'b0, 1'b0, 301);
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready: got %b want 0000", req_ready); end
        rst = 1'b0;
        set_beat(2, 1'b0, 1'b0, 1'b0, 32'h0);
        set_beat(0, 1'b1, 1'b1, 1'b1, 32'h70);
        set_beat(1, 1'b1, 1'b1, 1'b1, 32'h71);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b want 0", busy); end
        step();
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rm_next_grant: got %0d want 0", grant_id); end
        checks++; if (out_data !== 32'h70) begin errors++; $display("FAIL rm_next_data: got %h want 70", out_data); end
        step();
        clr_all();
    endtask

`ifdef PKT_ARB_WDOG_EN
    task automatic test_watchdog();
        do_reset();
        out_ready = 1'b1;
        set_beat(1, 1'b1, 1'b1, 1'b0, 400);
        step();
        #1;
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL wd_grant: got %0d want 1", grant_id); end
        step();
        set_beat(1, 1'b0, 1'b0, 1'b0, 32'h0);
        set_beat(2, 1'b1, 1'b1, 1'b1, 32'h80);
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++; if (wdog_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_stall k=%0d: got err=%b busy=%b want 0 1", k, wdog_err, busy); end
            step();
        end
        #1;
        checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b want 1", wdog_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy_fall: got %b want 0", busy); end
        step();
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wd_one_cycle: got %b want 0", wdog_err); end
        checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL wd_next_grant: got %0d busy=%b want 2 1", grant_id, busy); end
        step();
        clr_all();
    endtask
`endif

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        clr_all();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_preempt();
        test_backpressure();
        test_reset_mid_packet();
`ifdef PKT_ARB_WDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
